// File: rtl/hidden_cpu_core.sv
// hidden_cpu_core: 4-register load/store core with a post-reset RAM clear,
// a valid/ready instruction port and a multi-cycle data-memory access.
module hidden_cpu_core #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned PC_W      = 8,
  parameter int unsigned MEM_DEPTH = 16,
  parameter int unsigned MEM_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [7:0]        instr,
  output logic              instr_ready,
  output logic [DATA_W-1:0] dout,
  output logic              carry,
  output logic [PC_W-1:0]   pc
);

  localparam int unsigned ADDR_W = $clog2(MEM_DEPTH);

  localparam logic [1:0] CLEAR = 2'd0;
  localparam logic [1:0] IDLE  = 2'd1;
  localparam logic [1:0] MEM   = 2'd2;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_LOGIC = 2'b10;

  logic [1:0]        state, stateNext;
  logic [DATA_W-1:0] regs [4];
  logic [DATA_W-1:0] regsNext [4];
  logic [DATA_W-1:0] ram [MEM_DEPTH];
  logic [ADDR_W-1:0] clrIdx, clrIdxNext;
  logic [ADDR_W-1:0] memAddr, memAddrNext;
  logic [DATA_W-1:0] memData, memDataNext;
  logic              memStore, memStoreNext;
  logic [2:0]        memCnt, memCntNext;
  logic              carryNext;
  logic              selOut, selOutNext;
  logic [PC_W-1:0]   pcNext;

  logic              ramWe;
  logic [ADDR_W-1:0] ramAddr;
  logic [DATA_W-1:0] ramWdata;

  logic [1:0]        op, rA, rB, sub;
  logic [DATA_W-1:0] valA, valB;
  logic [DATA_W:0]   sum;
  logic [ADDR_W-1:0] accAddr;

  assign op  = instr[7:6];
  assign rA  = instr[5:4];
  assign rB  = instr[3:2];
  assign sub = instr[1:0];

  // Next-state, register-file, RAM-port and flag computation
  always_comb begin
    stateNext    = state;
    regsNext     = regs;
    clrIdxNext   = clrIdx;
    memAddrNext  = memAddr;
    memDataNext  = memData;
    memStoreNext = memStore;
    memCntNext   = memCnt;
    carryNext    = carry;
    selOutNext   = selOut;
    pcNext       = pc;
    ramWe        = 1'b0;
    ramAddr      = clrIdx;
    ramWdata     = '0;
    valA         = regs[rA];
    valB         = regs[rB];
    sum          = {1'b0, valA} + {1'b0, valB};
    accAddr      = valA[ADDR_W-1:0];

    case (state)
      CLEAR: begin
        ramWe      = 1'b1;
        ramAddr    = clrIdx;
        ramWdata   = '0;
        clrIdxNext = clrIdx + ADDR_W'(1);
        if (clrIdx == ADDR_W'(MEM_DEPTH - 1)) stateNext = IDLE;
      end
      IDLE: begin
        if (instr_valid && instr_ready) begin
          pcNext = pc + PC_W'(1);
          case (op)
            OP_ADD: {carryNext, regsNext[rA]} = sum;
            OP_SUB: begin
              regsNext[rA] = valA - valB;
              carryNext    = (valA < valB);
            end
            OP_LOGIC: begin
              case (sub)
                2'b00:   regsNext[rA] = valA & valB;
                2'b01:   regsNext[rA] = valA | valB;
                2'b10:   regsNext[rA] = valA ^ valB;
                default: regsNext[rA] = ~valB;
              endcase
            end
            default: begin
              case (sub)
                2'b00, 2'b01: begin
                  if (MEM_LAT == 0) begin
                    if (sub[0]) begin
                      ramWe    = 1'b1;
                      ramAddr  = accAddr;
                      ramWdata = regs[3];
                    end else begin
                      regsNext[3] = ram[accAddr];
                    end
                  end else begin
                    stateNext    = MEM;
                    memCntNext   = 3'(MEM_LAT);
                    memAddrNext  = accAddr;
                    memDataNext  = regs[3];
                    memStoreNext = sub[0];
                  end
                end
                2'b10: begin
                  if (carry) begin
                    pcNext    = pc + PC_W'(valB);
                    carryNext = 1'b0;
                  end
                end
                default: selOutNext = ~selOut;
              endcase
            end
          endcase
        end
      end
      MEM: begin
        memCntNext = memCnt - 3'd1;
        if (memCnt == 3'd1) begin
          stateNext = IDLE;
          if (memStore) begin
            ramWe    = 1'b1;
            ramAddr  = memAddr;
            ramWdata = memData;
          end else begin
            regsNext[3] = ram[memAddr];
          end
        end
      end
      default: stateNext = CLEAR;
    endcase
  end

  // State, architectural registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= CLEAR;
      clrIdx      <= '0;
      memAddr     <= '0;
      memData     <= '0;
      memStore    <= 1'b0;
      memCnt      <= '0;
      selOut      <= 1'b0;
      for (int i = 0; i < 4; i++) regs[i] <= DATA_W'(i);
      carry       <= 1'b0;
      pc          <= '0;
      instr_ready <= 1'b0;
      dout        <= DATA_W'(3);
    end else begin
      state       <= stateNext;
      clrIdx      <= clrIdxNext;
      memAddr     <= memAddrNext;
      memData     <= memDataNext;
      memStore    <= memStoreNext;
      memCnt      <= memCntNext;
      selOut      <= selOutNext;
      regs        <= regsNext;
      carry       <= carryNext;
      pc          <= pcNext;
      instr_ready <= (stateNext == IDLE);
      dout        <= selOutNext ? DATA_W'(pcNext) : regsNext[3];
    end
  end

  // Data RAM write port; reset suppresses any pending write
  always_ff @(posedge clk) begin
    if (ramWe && !rst) ram[ramAddr] <= ramWdata;
  end

endmodule

// File: tb/tb_hidden_cpu_core.sv
// Self-checking bench for hidden_cpu_core: behavioural model plus directed
// and randomized instruction streams.
module tb_hidden_cpu_core;

  localparam int LAT   = 2;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       instr_valid = 1'b0;
  logic [7:0] instr = 8'h00;
  logic       instr_ready;
  logic [7:0] dout;
  logic       carry;
  logic [7:0] pc;

  hidden_cpu_core #(.DATA_W(8), .PC_W(8), .MEM_DEPTH(DEPTH), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .dout(dout), .carry(carry), .pc(pc)
  );

  always #5 clk = ~clk;

  int nCmp = 0;
  int nBad = 0;
  bit chkEn = 1'b0;

  // Architectural model
  int mR [4];
  int mRam [DEPTH];
  int mPc, mC, mSel, clearLeft, busy, pAddr, pData;
  bit pStore;

  task automatic cmp(input string name, input int act, input int exp);
    nCmp++;
    if (act != exp) begin
      nBad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] enc(input int op, input int a, input int b, input int s);
    return 8'((op << 6) | (a << 4) | (b << 2) | s);
  endfunction

  // Model advances one clock edge using the rules for each instruction
  always @(posedge clk) begin
    int op, a, b, s, va, vb, npc;
    if (rst) begin
      for (int i = 0; i < 4; i++) mR[i] = i;
      mPc = 0; mC = 0; mSel = 0; clearLeft = DEPTH; busy = 0;
    end else if (clearLeft > 0) begin
      mRam[DEPTH - clearLeft] = 0;
      clearLeft--;
    end else if (busy > 0) begin
      busy--;
      if (busy == 0) begin
        if (pStore) mRam[pAddr] = pData;
        else        mR[3] = mRam[pAddr];
      end
    end else if (instr_valid) begin
      op = int'(instr[7:6]); a = int'(instr[5:4]); b = int'(instr[3:2]); s = int'(instr[1:0]);
      va = mR[a]; vb = mR[b];
      npc = (mPc + 1) % 256;
      case (op)
        0: begin mR[a] = (va + vb) % 256; mC = (va + vb > 255) ? 1 : 0; end
        1: begin mC = (va < vb) ? 1 : 0; mR[a] = (va - vb + 256) % 256; end
        2: case (s)
             0: mR[a] = va & vb;
             1: mR[a] = va | vb;
             2: mR[a] = va ^ vb;
             default: mR[a] = 255 - vb;
           endcase
        default: case (s)
             0, 1: begin pStore = (s == 1); pAddr = va % DEPTH; pData = mR[3]; busy = LAT; end
             2: if (mC != 0) begin npc = (mPc + vb) % 256; mC = 0; end
             default: mSel = 1 - mSel;
           endcase
      endcase
      mPc = npc;
    end
  end

  // Per-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (chkEn) begin
      cmp("ready", int'(instr_ready), (clearLeft == 0 && busy == 0) ? 1 : 0);
      cmp("pc", int'(pc), mPc);
      cmp("carry", int'(carry), mC);
      cmp("dout", int'(dout), (mSel != 0) ? mPc : mR[3]);
    end
  end

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chkEn = 1'b1;
  endtask

  task automatic waitReady(output int n);
    n = 0;
    while (!instr_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) begin
      nCmp++;
      nBad++;
      $display("FAIL ready_timeout: instr_ready still 0 after %0d cycles", n);
    end
  endtask

  task automatic send(input logic [7:0] code);
    int n;
    waitReady(n);
    instr = code;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  initial begin
    int n;
    int bits [7] = '{0, 1, 0, 0, 1, 0, 1};

    // T1: reset and clear sequence
    doReset();
    waitReady(n);
    cmp("t1_clear_cycles", n, 16);
    cmp("t1_dout", int'(dout), 3);
    cmp("t1_pc", int'(pc), 0);

    // T2: repeated doubling of r3
    for (int i = 0; i < 7; i++) begin
      send(enc(0, 3, 3, 0));
      if (i == 5) cmp("t2_dout6", int'(dout), 192);
    end
    cmp("t2_dout7", int'(dout), 128);
    cmp("t2_carry", int'(carry), 1);
    cmp("t2_pc", int'(pc), 7);

    // T3: borrow then taken / untaken branch
    doReset();
    send(enc(1, 0, 1, 0));
    cmp("t3_carry", int'(carry), 1);
    cmp("t3_model_r0", mR[0], 255);
    send(enc(3, 0, 2, 2));
    cmp("t3_brc_pc", int'(pc), 3);
    cmp("t3_brc_carry", int'(carry), 0);
    send(enc(3, 0, 2, 2));
    cmp("t3_brc2_pc", int'(pc), 4);

    // T4: build 0xA5 in r3, store, overwrite, load back
    doReset();
    send(enc(2, 3, 1, 0));
    for (int i = 0; i < 7; i++) begin
      send(enc(0, 3, 3, 0));
      if (bits[i] != 0) send(enc(0, 3, 1, 0));
    end
    cmp("t4_r3", int'(dout), 165);
    send(enc(3, 2, 0, 1));
    waitReady(n);
    cmp("t4_store_busy", n, 2);
    cmp("t4_model_ram2", mRam[2], 165);
    send(enc(2, 3, 0, 3));
    cmp("t4_not", int'(dout), 255);
    send(enc(3, 2, 0, 0));
    waitReady(n);
    cmp("t4_load", int'(dout), 165);

    // T5: output select toggle and pc wrap
    doReset();
    send(enc(3, 0, 0, 3));
    cmp("t5_dout_pc", int'(dout), 1);
    send(enc(3, 0, 0, 3));
    cmp("t5_dout_r3", int'(dout), 3);
    for (int i = 0; i < 253; i++) send(enc(0, 0, 0, 0));
    cmp("t5_pc_ff", int'(pc), 255);
    send(enc(0, 0, 0, 0));
    cmp("t5_pc_wrap", int'(pc), 0);

    // T6: reset during an in-flight LOAD
    doReset();
    send(enc(2, 3, 0, 3));
    send(enc(3, 2, 0, 1));
    send(enc(2, 3, 0, 0));
    send(enc(3, 2, 0, 0));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cmp("t6_r3_reset", int'(dout), 3);
    waitReady(n);
    cmp("t6_clear_cycles", n, 16);
    send(enc(3, 2, 0, 0));
    waitReady(n);
    cmp("t6_ram_cleared", int'(dout), 0);

    // Random stream, input changes every cycle, rare resets
    doReset();
    for (int i = 0; i < 3000; i++) begin
      instr = 8'($urandom);
      instr_valid = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    instr_valid = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
